// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - address map, FSM states and helpers for cpu_bus_responder
package cpu_bus_pkg;

  localparam logic [15:0] HRAM_LO      = 16'hFF80;
  localparam logic [15:0] HRAM_HI      = 16'hFFFE;
  localparam logic [15:0] IE_ADDR      = 16'hFFFF;
  localparam logic [15:0] BOOTOFF_ADDR = 16'hFF50;
  localparam logic [15:0] IPL_TOP      = 16'h00FF;
  localparam logic [7:0]  MMIO_PAGE    = 8'hFF;
  localparam logic [7:0]  OPEN_BUS     = 8'hFF;

  typedef enum logic {IDLE, RDATA} state_e;

  function automatic logic is_hram(input logic [15:0] a);
    return (a >= HRAM_LO) && (a <= HRAM_HI);
  endfunction

endpackage

// File: rtl/cpu_bus_responder_if.sv
// rtl/cpu_bus_responder_if.sv - CPU-side bus bundle between the core and the high-page responder
interface cpu_bus_if;
  logic [15:0] A;
  logic [7:0]  D_IN;
  logic        MREQ;
  logic        RD;
  logic        WR;
  logic [7:0]  D_OUT;
  logic        D_OE;
  logic        MMIO_REQ;
  logic        IPL_REQ;
  logic [7:0]  IE;
  logic        BOOT_OFF;
  logic        BUS_ERR;

  modport master (
    output A, D_IN, MREQ, RD, WR,
    input  D_OUT, D_OE, MMIO_REQ, IPL_REQ, IE, BOOT_OFF, BUS_ERR
  );

  modport slave (
    input  A, D_IN, MREQ, RD, WR,
    output D_OUT, D_OE, MMIO_REQ, IPL_REQ, IE, BOOT_OFF, BUS_ERR
  );
endinterface

// File: rtl/hram_127x8.sv
// rtl/hram_127x8.sv - 127x8 high RAM, synchronous write and registered read, no reset
module hram_127x8 (
  input  logic       CLK,
  input  logic       we,
  input  logic [6:0] waddr,
  input  logic [7:0] wdata,
  input  logic [6:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem_q [0:126];

  // Read samples the array before this edge's write lands, giving pre-write data.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/cpu_bus_responder.sv
// rtl/cpu_bus_responder.sv - high-page target: HRAM, IE, boot-ROM disable latch, region decode
// Optional: BOOTOFF_READBACK_EN makes FF50 read back {7'b1111111, BOOT_OFF}.
module cpu_bus_responder
  import cpu_bus_pkg::*;
(
  input  logic      CLK,
  input  logic      RESET,
  cpu_bus_if.slave  bus
);

  logic       rd_req, wr_req, bad_req;
  logic       own_hram, own_ie, own_boot, owned;
  logic [7:0] hram_rdata, dout, boot_rb;

  state_e     state_q, state_d;
  logic       sel_hram_q, sel_hram_d;
  logic [7:0] reg_data_q, reg_data_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] ie_q, ie_d;
  logic       boot_off_q, boot_off_d;
  logic       bus_err_q, bus_err_d;

  assign rd_req  = bus.MREQ & bus.RD & ~bus.WR;
  assign wr_req  = bus.MREQ & bus.WR & ~bus.RD;
  assign bad_req = bus.MREQ & bus.RD & bus.WR;

  assign own_hram = is_hram(bus.A);
  assign own_ie   = (bus.A == IE_ADDR);
  assign own_boot = (bus.A == BOOTOFF_ADDR);
  assign owned    = own_hram | own_ie | own_boot;

`ifdef BOOTOFF_READBACK_EN
  assign boot_rb = {7'b1111111, boot_off_q};
`else
  assign boot_rb = OPEN_BUS;
`endif

  hram_127x8 u_hram (
    .CLK   (CLK),
    .we    (wr_req & own_hram),
    .waddr (bus.A[6:0]),
    .wdata (bus.D_IN),
    .raddr (bus.A[6:0]),
    .rdata (hram_rdata)
  );

  // hold_q remembers whatever was last presented so D_OUT is stable once D_OE drops.
  assign dout = (state_q == RDATA) ? (sel_hram_q ? hram_rdata : reg_data_q) : hold_q;

  always_comb begin
    state_d    = IDLE;
    sel_hram_d = sel_hram_q;
    reg_data_d = reg_data_q;
    hold_d     = dout;
    ie_d       = ie_q;
    boot_off_d = boot_off_q;
    bus_err_d  = bad_req;
    if (rd_req && owned) begin
      state_d    = RDATA;
      sel_hram_d = own_hram;
      reg_data_d = own_ie ? ie_q : boot_rb;
    end
    if (wr_req) begin
      if (own_ie) begin
        ie_d = bus.D_IN;
      end
      if (own_boot && (bus.D_IN != 8'h00)) begin
        boot_off_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      sel_hram_q <= 1'b0;
      reg_data_q <= 8'h00;
      hold_q     <= 8'h00;
      ie_q       <= 8'h00;
      boot_off_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_hram_q <= sel_hram_d;
      reg_data_q <= reg_data_d;
      hold_q     <= hold_d;
      ie_q       <= ie_d;
      boot_off_q <= boot_off_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign bus.D_OUT    = dout;
  assign bus.D_OE     = (state_q == RDATA);
  assign bus.MMIO_REQ = (bus.A[15:8] == MMIO_PAGE);
  assign bus.IPL_REQ  = (bus.A <= IPL_TOP) & ~boot_off_q;
  assign bus.IE       = ie_q;
  assign bus.BOOT_OFF = boot_off_q;
  assign bus.BUS_ERR  = bus_err_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb/tb_cpu_bus_responder.sv - self-checking bench: memory-map model, directed and random traffic
module tb_cpu_bus_responder;

  logic CLK;
  logic RESET;
  cpu_bus_if bus ();

  cpu_bus_responder dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference: the target's address map as plain storage.
  byte unsigned hm [0:126];
  bit           hv [0:126];
  logic [7:0]   m_ie, m_dout;
  logic         m_boot, m_oe, m_err, m_known;

`ifdef BOOTOFF_READBACK_EN
  function automatic logic [7:0] boot_read(input logic b);
    return {7'b1111111, b};
  endfunction
`else
  function automatic logic [7:0] boot_read(input logic b);
    return (b === 1'bx) ? 8'hFF : 8'hFF;
  endfunction
`endif

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_oe    <= 1'b0;
      m_dout  <= 8'h00;
      m_known <= 1'b1;
      m_ie    <= 8'h00;
      m_boot  <= 1'b0;
      m_err   <= 1'b0;
    end else begin
      m_err <= bus.MREQ && bus.RD && bus.WR;
      m_oe  <= 1'b0;
      if (bus.MREQ && bus.RD && !bus.WR) begin
        if (bus.A >= 16'hFF80 && bus.A <= 16'hFFFE) begin
          m_oe    <= 1'b1;
          m_dout  <= hm[bus.A - 16'hFF80];
          m_known <= hv[bus.A - 16'hFF80];
        end else if (bus.A == 16'hFFFF) begin
          m_oe    <= 1'b1;
          m_dout  <= m_ie;
          m_known <= 1'b1;
        end else if (bus.A == 16'hFF50) begin
          m_oe    <= 1'b1;
          m_dout  <= boot_read(m_boot);
          m_known <= 1'b1;
        end
      end
      if (bus.MREQ && bus.WR && !bus.RD) begin
        if (bus.A >= 16'hFF80 && bus.A <= 16'hFFFE) begin
          hm[bus.A - 16'hFF80] <= bus.D_IN;
          hv[bus.A - 16'hFF80] <= 1'b1;
        end else if (bus.A == 16'hFFFF) begin
          m_ie <= bus.D_IN;
        end else if (bus.A == 16'hFF50 && bus.D_IN != 8'h00) begin
          m_boot <= 1'b1;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("d_oe", {7'b0, bus.D_OE}, {7'b0, m_oe});
      if (m_known) chk("d_out", bus.D_OUT, m_dout);
      chk("ie", bus.IE, m_ie);
      chk("boot_off", {7'b0, bus.BOOT_OFF}, {7'b0, m_boot});
      chk("bus_err", {7'b0, bus.BUS_ERR}, {7'b0, m_err});
      chk("mmio_req", {7'b0, bus.MMIO_REQ}, {7'b0, bus.A[15:8] == 8'hFF});
      chk("ipl_req", {7'b0, bus.IPL_REQ}, {7'b0, (bus.A <= 16'h00FF) && !m_boot});
    end
  end

  task automatic req(input logic [15:0] a, input logic [7:0] d,
                     input logic m, input logic r, input logic w);
    bus.A = a; bus.D_IN = d; bus.MREQ = m; bus.RD = r; bus.WR = w;
    @(posedge CLK);
    #1;
    bus.MREQ = 1'b0; bus.RD = 1'b0; bus.WR = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    req(a, d, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic rd(input logic [15:0] a);
    req(a, 8'h00, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic idle();
    req(bus.A, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  logic [15:0] ra;
  logic [1:0]  rs;

  initial begin
    RESET = 1'b1;
    bus.A = 16'h0000; bus.D_IN = 8'h00;
    bus.MREQ = 1'b0; bus.RD = 1'b0; bus.WR = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ie", bus.IE, 8'h00);
    chk("rst_boot", {7'b0, bus.BOOT_OFF}, 8'h00);
    chk("rst_oe", {7'b0, bus.D_OE}, 8'h00);
    chk("rst_dout", bus.D_OUT, 8'h00);
    chk("rst_err", {7'b0, bus.BUS_ERR}, 8'h00);
    bus.A = 16'h0040; #1;
    chk("ipl_0040", {7'b0, bus.IPL_REQ}, 8'h01);
    chk("mmio_0040", {7'b0, bus.MMIO_REQ}, 8'h00);
    bus.A = 16'hFF80; #1;
    chk("mmio_ff80", {7'b0, bus.MMIO_REQ}, 8'h01);
    RESET = 1'b0;
    chk_en = 1'b1;

    wr(16'hFF80, 8'h5A);
    wr(16'hFFFE, 8'hA5);
    rd(16'hFF80);
    chk("b2b_oe0", {7'b0, bus.D_OE}, 8'h01);
    chk("b2b_d0", bus.D_OUT, 8'h5A);
    rd(16'hFFFE);
    chk("b2b_oe1", {7'b0, bus.D_OE}, 8'h01);
    chk("b2b_d1", bus.D_OUT, 8'hA5);
    idle();
    chk("hold_oe", {7'b0, bus.D_OE}, 8'h00);
    chk("hold_d", bus.D_OUT, 8'hA5);

    wr(16'hFFFF, 8'h1F);
    chk("ie_wr", bus.IE, 8'h1F);
    rd(16'hFFFF);
    chk("ie_rd", bus.D_OUT, 8'h1F);
    rd(16'hFF40);
    chk("unowned_oe", {7'b0, bus.D_OE}, 8'h00);

    rd(16'hFF50);
    chk("boot_rb_oe", {7'b0, bus.D_OE}, 8'h01);
`ifdef BOOTOFF_READBACK_EN
    chk("boot_rb_pre", bus.D_OUT, 8'hFE);
`else
    chk("boot_rb_pre", bus.D_OUT, 8'hFF);
`endif
    wr(16'hFF50, 8'h00);
    chk("boot_wr0", {7'b0, bus.BOOT_OFF}, 8'h00);
    wr(16'hFF50, 8'h01);
    chk("boot_wr1", {7'b0, bus.BOOT_OFF}, 8'h01);
    bus.A = 16'h0000; #1;
    chk("ipl_off", {7'b0, bus.IPL_REQ}, 8'h00);
    rd(16'hFF50);
    chk("boot_rb_post", bus.D_OUT, 8'hFF);

    req(16'hFF80, 8'h33, 1'b1, 1'b1, 1'b1);
    chk("illegal_err", {7'b0, bus.BUS_ERR}, 8'h01);
    chk("illegal_oe", {7'b0, bus.D_OE}, 8'h00);
    idle();
    chk("illegal_pulse", {7'b0, bus.BUS_ERR}, 8'h00);
    rd(16'hFF80);
    chk("illegal_hram", bus.D_OUT, 8'h5A);
    req(16'hFF80, 8'h33, 1'b0, 1'b1, 1'b1);
    chk("nomreq_err", {7'b0, bus.BUS_ERR}, 8'h00);
    chk("nomreq_oe", {7'b0, bus.D_OE}, 8'h00);

    rd(16'hFFFF);
    chk("midrd_oe", {7'b0, bus.D_OE}, 8'h01);
    #2 RESET = 1'b1;
    #1;
    chk("midrd_oe_async", {7'b0, bus.D_OE}, 8'h00);
    chk("midrd_ie_async", bus.IE, 8'h00);
    @(posedge CLK);
    #1 RESET = 1'b0;
    idle();
    chk("post_oe", {7'b0, bus.D_OE}, 8'h00);
    chk("post_ie", bus.IE, 8'h00);
    chk("post_boot", {7'b0, bus.BOOT_OFF}, 8'h00);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        #1 RESET = 1'b1;
        #1 RESET = 1'b0;
        idle();
      end else begin
        case ($urandom_range(0, 5))
          0, 1:    ra = 16'hFF80 + 16'($urandom_range(0, 126));
          2:       ra = 16'hFFFF;
          3:       ra = 16'hFF50;
          4:       ra = 16'($urandom_range(0, 255));
          default: ra = 16'($urandom);
        endcase
        rs = 2'($urandom_range(0, 3));
        req(ra, ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom),
            ($urandom_range(0, 7) != 0), rs[1], rs[0]);
      end
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
